// File: rtl/dsp48a1_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dsp48a1_mac_seq
//  Description : Multiply-accumulate sequencer for a single DSP48A1 slice.
//                Accepts a job of len (A,B) pairs and streams them into the
//                slice. It generates the per-sample OPMODE and CE pattern,
//                drains the slice pipeline, and returns the 48-bit sum on a
//                valid/ready result port.
//  Revision    : 1.0 - initial release
// ============================================================================
module dsp48a1_mac_seq #(
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    // job request
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             sub,
    // sample stream
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [17:0]      s_a,
    input  logic [17:0]      s_b,
    // result port
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic             busy,
    // DSP48A1 slice control
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic             dsp_cea,
    output logic             dsp_ceb,
    output logic             dsp_cem,
    output logic             dsp_cep,
    output logic             dsp_ceopmode,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_rst,
    input  logic [47:0]      dsp_p
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [LEN_W-1:0] c_ONE = LEN_W'(1);

    // Z mux selections for the slice post-adder
    localparam logic [1:0] c_Z_ZERO  = 2'b00;
    localparam logic [1:0] c_Z_PCOUT = 2'b10;
    // X mux selection: M register
    localparam logic [1:0] c_X_M     = 2'b01;

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_remaining;
    logic             r_sub;
    logic             r_first;
    logic             r_v1, r_v2, r_v3;
    logic             r_last1, r_last2, r_last3;
    logic [7:0]       r_opmode;
    logic [47:0]      r_res_data;
    logic             r_res_valid;
    logic             w_hs;

    assign s_ready      = (r_state == c_LOAD) && (r_remaining != '0);
    assign w_hs         = s_valid & s_ready;

    // A1/B1 capture the sample on the accepting edge itself
    assign dsp_a        = s_a;
    assign dsp_b        = s_b;
    assign dsp_cea      = w_hs;
    assign dsp_ceb      = w_hs;

    // M and the slice OPMODE register load one cycle after acceptance, P one cycle later
    assign dsp_cem      = r_v1;
    assign dsp_ceopmode = r_v1;
    assign dsp_cep      = r_v2;
    assign dsp_opmode   = r_opmode;
    assign dsp_rst      = RST;

    assign busy         = (r_state != c_IDLE);
    assign res_valid    = r_res_valid;
    assign res_data     = r_res_data;

    // Tag each accepted sample as it moves through the M and P stages, and stage its OPMODE
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_last1  <= 1'b0;
            r_last2  <= 1'b0;
            r_last3  <= 1'b0;
            r_opmode <= 8'h00;
        end else begin
            r_v1    <= w_hs;
            r_last1 <= w_hs && (r_remaining == c_ONE);
            r_v2    <= r_v1;
            r_v3    <= r_v2;
            r_last2 <= r_last1;
            r_last3 <= r_last2;
            // The first product of a job starts from zero; later ones add onto P
            if (w_hs) begin
                r_opmode <= {r_sub, 3'b000, (r_first ? c_Z_ZERO : c_Z_PCOUT), c_X_M};
            end
        end
    end

    // Job control: accept, stream, drain, then hold the result until taken
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= c_IDLE;
            r_remaining <= '0;
            r_sub       <= 1'b0;
            r_first     <= 1'b0;
            r_res_data  <= 48'd0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_sub       <= sub;
                        r_res_data  <= 48'd0;
                        r_res_valid <= 1'b0;
                        if (len == '0) begin
                            // Empty job: the slice is never touched
                            r_state <= c_DONE;
                        end else begin
                            r_remaining <= len;
                            r_first     <= 1'b1;
                            r_state     <= c_LOAD;
                        end
                    end
                end
                c_LOAD: begin
                    if (w_hs) begin
                        r_remaining <= r_remaining - c_ONE;
                        r_first     <= 1'b0;
                        if (r_remaining == c_ONE) begin
                            r_state <= c_DRAIN;
                        end
                    end
                end
                c_DRAIN: begin
                    // P holds the complete sum while the last sample's tag is in stage 3
                    if (r_v3 && r_last3) begin
                        r_res_data  <= dsp_p;
                        r_res_valid <= 1'b1;
                        r_state     <= c_DONE;
                    end
                end
                c_DONE: begin
                    // The empty-job path enters with valid low and raises it here
                    if (!r_res_valid) begin
                        r_res_valid <= 1'b1;
                    end else if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dsp48a1_mac_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dsp48a1_mac_seq
//  Description : Self-checking bench for dsp48a1_mac_seq with a behavioural
//                DSP48A1 slice model and result/OPMODE scoreboards.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp48a1_mac_seq;

    localparam int LEN_W = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             sub = 1'b0;
    logic             s_valid = 1'b0;
    logic [17:0]      s_a = '0;
    logic [17:0]      s_b = '0;
    logic             res_ready = 1'b0;

    logic             s_ready, res_valid, busy;
    logic [47:0]      res_data;
    logic [17:0]      dsp_a, dsp_b;
    logic             dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode, dsp_rst;
    logic [7:0]       dsp_opmode;
    logic [47:0]      dsp_p;

    dsp48a1_mac_seq #(.LEN_W(LEN_W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .len(len), .sub(sub),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb),
        .dsp_cem(dsp_cem), .dsp_cep(dsp_cep), .dsp_ceopmode(dsp_ceopmode),
        .dsp_opmode(dsp_opmode), .dsp_rst(dsp_rst), .dsp_p(dsp_p)
    );

    always #5 CLK = ~CLK;

    // ---------------- DSP48A1 slice model (A1/B1, M, OPMODE, P registers) ----------------
    logic [17:0] m_a1 = '0, m_b1 = '0;
    logic [35:0] m_m = '0;
    logic [7:0]  m_opm = '0;
    logic [47:0] m_p = '0;
    assign dsp_p = m_p;

    always @(posedge CLK) begin : slice_model
        logic [47:0] zmux, xmux;
        zmux = (m_opm[3:2] == 2'b10) ? m_p : 48'd0;
        xmux = (m_opm[1:0] == 2'b01) ? {12'd0, m_m} : 48'd0;
        if (dsp_rst) begin
            m_a1 <= '0; m_b1 <= '0; m_m <= '0; m_opm <= '0; m_p <= '0;
        end else begin
            if (dsp_cea) m_a1 <= dsp_a;
            if (dsp_ceb) m_b1 <= dsp_b;
            if (dsp_cem) m_m <= m_a1 * m_b1;
            if (dsp_ceopmode) m_opm <= dsp_opmode;
            if (dsp_cep) m_p <= m_opm[7] ? (zmux - xmux) : (zmux + xmux);
        end
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_acc    = 0;
    int t_start  = 0;
    int cep_cnt  = 0;
    int hs_cnt   = 0;
    int srdy_cnt = 0;

    logic [47:0] exp_res[$];
    logic [7:0]  exp_opm[$];
    logic [17:0] va[16];
    logic [17:0] vb[16];

    always @(posedge CLK) cyc <= cyc + 1;

    // OPMODE scoreboard and event counters, sampled mid-cycle
    always @(negedge CLK) begin
        logic [7:0] e;
        if (dsp_cep === 1'b1) cep_cnt++;
        if (s_ready === 1'b1) srdy_cnt++;
        if ((s_valid & s_ready) === 1'b1) hs_cnt++;
        if (dsp_ceopmode === 1'b1) begin
            n_checks++;
            if (exp_opm.size() == 0) begin
                n_fail++;
                $display("FAIL opmode_unexpected: got %02h, required no OPMODE load", dsp_opmode);
            end else begin
                e = exp_opm.pop_front();
                if (dsp_opmode !== e) begin
                    n_fail++;
                    $display("FAIL opmode_seq: got %02h, required %02h", dsp_opmode, e);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [47:0] model_sum(input int n, input bit neg);
        logic [47:0] acc = '0;
        logic [35:0] p36;
        for (int i = 0; i < n; i++) begin
            p36 = va[i] * vb[i];
            acc = neg ? (acc - {12'd0, p36}) : (acc + {12'd0, p36});
        end
        return acc;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_job(input int n, input bit neg, input bit push_res);
        start = 1'b1;
        len   = LEN_W'(n);
        sub   = neg;
        if (push_res) exp_res.push_back(model_sum(n, neg));
        for (int i = 0; i < n; i++)
            exp_opm.push_back({neg, 3'b000, (i == 0) ? 2'b00 : 2'b10, 2'b01});
        @(negedge CLK);
        t_start = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic send_samples(input int n, input int gap);
        bit ok;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_a = va[i];
            s_b = vb[i];
            ok = 1'b0;
            for (int t = 0; t < 64 && !ok; t++) begin
                @(negedge CLK);
                if (s_ready === 1'b1) ok = 1'b1;
                else step();
            end
            if (!ok) begin
                n_checks++; n_fail++;
                $display("FAIL accept_timeout: sample %0d not accepted, s_ready=%b required 1", i, s_ready);
                s_valid = 1'b0;
                return;
            end
            t_acc = cyc;
            step();
            s_valid = 1'b0;
            repeat (gap) step();
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge CLK);
            if (res_valid === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL res_valid_timeout: res_valid=%b, required 1", res_valid);
        end
    endtask

    task automatic release_result();
        step();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b1;
        repeat (3) step();
        @(negedge CLK);
        n_checks++;
        if (dsp_rst !== 1'b1) begin n_fail++; $display("FAIL rst_passthrough: got %b, required 1", dsp_rst); end
        step();
        RST = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (s_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: s_ready=%b res_valid=%b busy=%b, required 0 0 0", s_ready, res_valid, busy);
        end
        n_checks++;
        if (res_data !== 48'd0 || dsp_opmode !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: res_data=%h opmode=%h, required 0 00", res_data, dsp_opmode);
        end
        n_checks++;
        if ({dsp_cem, dsp_cep, dsp_ceopmode, dsp_rst} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ce: cem/cep/ceop/rst=%b, required 0000", {dsp_cem, dsp_cep, dsp_ceopmode, dsp_rst});
        end
        step();
    endtask

    task automatic run_and_check(input string name, input int n, input bit neg, input int gap);
        bit ok;
        logic [47:0] e;
        start_job(n, neg, 1'b1);
        send_samples(n, gap);
        wait_valid(ok);
        if (ok) begin
            n_checks++;
            if (cyc != t_acc + 4) begin
                n_fail++;
                $display("FAIL %s_latency: res_valid %0d cycles after last accept, required 4", name, cyc - t_acc);
            end
            e = exp_res.pop_front();
            n_checks++;
            if (res_data !== e) begin
                n_fail++;
                $display("FAIL %s_result: got %h, required %h", name, res_data, e);
            end
        end
        release_result();
        @(negedge CLK);
        n_checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_return_idle: busy=%b res_valid=%b, required 0 0", name, busy, res_valid);
        end
        step();
    endtask

    task automatic test_basic();
        va[0] = 18'd2; vb[0] = 18'd3;
        va[1] = 18'd4; vb[1] = 18'd5;
        va[2] = 18'd1; vb[2] = 18'd7;
        run_and_check("basic", 3, 1'b0, 0);
    endtask

    task automatic test_gapped();
        int c0;
        for (int i = 0; i < 4; i++) begin va[i] = 18'h3FFFF; vb[i] = 18'h3FFFF; end
        c0 = cep_cnt;
        run_and_check("gapped", 4, 1'b0, 2);
        n_checks++;
        if (cep_cnt - c0 != 4) begin
            n_fail++;
            $display("FAIL gapped_cep_pulses: got %0d, required 4", cep_cnt - c0);
        end
    endtask

    task automatic test_sub();
        va[0] = 18'd5; vb[0] = 18'd6;
        va[1] = 18'd1; vb[1] = 18'd2;
        run_and_check("sub", 2, 1'b1, 0);
    endtask

    task automatic test_zero_and_backpressure();
        bit ok;
        int s0;
        logic [47:0] e;
        s0 = srdy_cnt;
        start_job(0, 1'b0, 1'b1);
        wait_valid(ok);
        if (ok) begin
            n_checks++;
            if (cyc != t_start + 2) begin
                n_fail++;
                $display("FAIL zero_latency: res_valid %0d cycles after start, required 2", cyc - t_start);
            end
            e = exp_res.pop_front();
            n_checks++;
            if (res_data !== e) begin n_fail++; $display("FAIL zero_result: got %h, required %h", res_data, e); end
        end
        release_result();
        @(negedge CLK);
        n_checks++;
        if (srdy_cnt != s0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_no_stream: s_ready cycles=%0d busy=%b, required 0 0", srdy_cnt - s0, busy);
        end
        // second job, result held under backpressure while start is waved
        va[0] = 18'd7; vb[0] = 18'd9;
        step();
        start_job(1, 1'b0, 1'b1);
        send_samples(1, 0);
        wait_valid(ok);
        e = exp_res.pop_front();
        step();
        start = 1'b1;
        len   = LEN_W'(5);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== e) begin
                n_fail++;
                $display("FAIL hold_stable: cycle %0d res_valid=%b data=%h, required 1 %h", k, res_valid, res_data, e);
            end
            step();
        end
        start = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ignored: busy=%b s_ready=%b after release, required 0 0", busy, s_ready);
        end
        step();
    endtask

    task automatic test_reset_drain();
        int seen;
        va[0] = 18'd10; vb[0] = 18'd30;
        va[1] = 18'd20; vb[1] = 18'd40;
        start_job(2, 1'b0, 1'b0);
        send_samples(2, 0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        exp_opm.delete();
        @(negedge CLK);
        n_checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res_data !== 48'd0) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b res_valid=%b data=%h, required 0 0 0", busy, res_valid, res_data);
        end
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (res_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL abort_no_valid: res_valid high %0d cycles, required 0", seen); end
        step();
        va[0] = 18'd3; vb[0] = 18'd3;
        run_and_check("after_abort", 1, 1'b0, 0);
    endtask

    task automatic test_max_len();
        int h0;
        for (int i = 0; i < 15; i++) begin va[i] = 18'd1; vb[i] = 18'd1; end
        h0 = hs_cnt;
        run_and_check("max_len", 15, 1'b0, 0);
        n_checks++;
        if (hs_cnt - h0 != 15) begin
            n_fail++;
            $display("FAIL max_len_handshakes: got %0d, required 15", hs_cnt - h0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_sub();
        test_zero_and_backpressure();
        test_reset_drain();
        test_max_len();
        n_checks++;
        if (exp_opm.size() != 0) begin
            n_fail++;
            $display("FAIL opmode_leftover: %0d OPMODE loads missing, required 0", exp_opm.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
